// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and grant owners.
package mem_arb_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    typedef logic gnt_t;
    localparam gnt_t GNT_CPU = 1'b0;
    localparam gnt_t GNT_EXT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU port, external port and memory handshake signals around the arbiter.
// master = arbiter side, slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Requesters hold req (and we/addr/wdata) until the cycle their done pulse is sampled;
    // memory answers a BUSY-phase mem_req with a single-cycle mem_ack carrying mem_rdata.
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          cpu_err;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata;
    logic          ext_done;
    logic          ext_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_done, ext_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_done, ext_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Watchdog counter for the BUSY phase: counts enabled cycles, saturates at TIMEOUT-1.
module arb_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the unified instruction/data memory, one access in flight.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build is fixed CPU priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.master  bus,
    output state_t              state_o
);
    state_t        state_q, state_d;
    gnt_t          gnt_q;
    gnt_t          win;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] ext_rdata_q;
    logic          expired;
    logic          any_req;

    assign any_req = bus.cpu_req | bus.ext_req;

`ifdef MEM_ARB_RR_EN
    gnt_t last_grant_q;

    // On a tie the port that lost the previous grant wins.
    always_comb begin
        win = bus.cpu_req ? GNT_CPU : GNT_EXT;
        if (bus.cpu_req && bus.ext_req) begin
            win = (last_grant_q == GNT_CPU) ? GNT_EXT : GNT_CPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GNT_EXT;
        end else if ((state_q == IDLE) && any_req) begin
            last_grant_q <= win;
        end
    end
`else
    always_comb begin
        win = bus.cpu_req ? GNT_CPU : GNT_EXT;
    end
`endif

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q == IDLE),
        .en      (state_q == BUSY),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (bus.mem_ack || expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is captured once at grant; requesters are not re-sampled while pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q       <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else if ((state_q == IDLE) && any_req) begin
            gnt_q   <= win;
            we_q    <= (win == GNT_CPU) ? bus.cpu_we    : bus.ext_we;
            addr_q  <= (win == GNT_CPU) ? bus.cpu_addr  : bus.ext_addr;
            wdata_q <= (win == GNT_CPU) ? bus.cpu_wdata : bus.ext_wdata;
        end else if (state_q == BUSY) begin
            if (bus.mem_ack) begin
                err_q <= 1'b0;
                if (!we_q) begin
                    if (gnt_q == GNT_CPU) cpu_rdata_q <= bus.mem_rdata;
                    else                  ext_rdata_q <= bus.mem_rdata;
                end
            end else if (expired) begin
                err_q <= 1'b1;
                if (gnt_q == GNT_CPU) cpu_rdata_q <= '0;
                else                  ext_rdata_q <= '0;
            end
        end
    end

    always_comb begin
        bus.mem_req   = (state_q == BUSY);
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.cpu_done  = (state_q == RESP) && (gnt_q == GNT_CPU);
        bus.ext_done  = (state_q == RESP) && (gnt_q == GNT_EXT);
        bus.cpu_err   = bus.cpu_done && err_q;
        bus.ext_err   = bus.ext_done && err_q;
        bus.cpu_rdata = cpu_rdata_q;
        bus.ext_rdata = ext_rdata_q;
        state_o       = state_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (both MEM_ARB_RR_EN builds).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TIMEOUT = 15;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_t st;
    int     checks = 0;
    int     errors = 0;
    logic [31:0] exp_cpu_rd = '0;
    logic [31:0] exp_ext_rd = '0;
    logic [31:0] exp_q[$];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (st)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req_seen", 32'(bus.mem_req), 32'd1);
    endtask

    // Issue one access on a port from IDLE, ack in BUSY cycle nbusy, check the response.
    task automatic run_txn(input bit is_ext, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd, input int nbusy);
        int n;
        if (is_ext) begin
            bus.ext_req = 1; bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata;
        end else begin
            bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        wait_busy(n);
        chk("grant_latency", 32'(n), 32'd1);
        for (int b = 0; b < nbusy; b++) begin
            chk("busy_mem_req", 32'(bus.mem_req), 32'd1);
            chk("busy_mem_we", 32'(bus.mem_we), 32'(we));
            chk("busy_mem_addr", bus.mem_addr, addr);
            chk("busy_mem_wdata", bus.mem_wdata, wdata);
            if (b == nbusy - 1) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rd;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        if (!we && is_ext) exp_ext_rd = rd;
        if (!we && !is_ext) exp_cpu_rd = rd;
        chk("resp_mem_req", 32'(bus.mem_req), 32'd0);
        chk("resp_cpu_done", 32'(bus.cpu_done), 32'(!is_ext));
        chk("resp_ext_done", 32'(bus.ext_done), 32'(is_ext));
        chk("resp_cpu_err", 32'(bus.cpu_err), 32'd0);
        chk("resp_ext_err", 32'(bus.ext_err), 32'd0);
        chk("resp_cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
        chk("resp_ext_rdata", bus.ext_rdata, exp_ext_rd);
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b0;
        @(negedge clk);
        chk("after_done_low", 32'(bus.cpu_done | bus.ext_done), 32'd0);
        chk("after_state", 32'(st), 32'(IDLE));
    endtask

    initial begin
        int n;
        int cnt;
        int cpu_n;
        int ext_n;
        logic [31:0] e;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;
        do_reset();

        chk("rst_state", 32'(st), 32'(IDLE));
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_done", 32'({bus.cpu_done, bus.ext_done, bus.cpu_err, bus.ext_err}), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_ext_rdata", bus.ext_rdata, 32'd0);

        run_txn(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        run_txn(1'b1, 1'b1, 32'h40, 32'h1234, 32'h0, 3);
        run_txn(1'b0, 1'b1, 32'h104, 32'h55AA, 32'h0, 2);

        // Both ports contend for four accesses each.
        do_reset();
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h200 + 32'(i));
            exp_q.push_back(32'h300 + 32'(i));
        end
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h300 + 32'(i));
`endif
        cpu_n = 0;
        ext_n = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h200; bus.cpu_wdata = '0;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h300; bus.ext_wdata = '0;
        wait_busy(n);
        chk("tie_first_latency", 32'(n), 32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tie_addr", bus.mem_addr, e);
            bus.mem_ack = 1'b1;
            bus.mem_rdata = ~e;
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (e[8]) begin
                chk("tie_ext_done", 32'(bus.ext_done), 32'd1);
                chk("tie_ext_rdata", bus.ext_rdata, ~e);
                ext_n++;
                if (ext_n == 4) bus.ext_req = 0;
                else bus.ext_addr = 32'h300 + 32'(ext_n);
            end else begin
                chk("tie_cpu_done", 32'(bus.cpu_done), 32'd1);
                chk("tie_cpu_rdata", bus.cpu_rdata, ~e);
                cpu_n++;
                if (cpu_n == 4) bus.cpu_req = 0;
                else bus.cpu_addr = 32'h200 + 32'(cpu_n);
            end
            if (exp_q.size() > 0) begin
                wait_busy(n);
                chk("tie_bubble", 32'(n), 32'd2);
            end
        end
        exp_cpu_rd = ~32'h203;
        @(negedge clk);
        chk("tie_idle", 32'(st), 32'(IDLE));

        // Watchdog: memory never answers.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h80;
        wait_busy(n);
        cnt = 0;
        while (bus.mem_req && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_busy_cycles", 32'(cnt), 32'(TIMEOUT));
        chk("to_cpu_done", 32'(bus.cpu_done), 32'd1);
        chk("to_cpu_err", 32'(bus.cpu_err), 32'd1);
        chk("to_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("to_ext_done", 32'(bus.ext_done), 32'd0);
        exp_cpu_rd = '0;
        bus.cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("stray_done", 32'(bus.cpu_done | bus.ext_done), 32'd0);
        chk("stray_mem_req", 32'(bus.mem_req), 32'd0);
        chk("stray_state", 32'(st), 32'(IDLE));
        chk("stray_rdata", bus.cpu_rdata, 32'd0);

        // Reset in the middle of a BUSY phase.
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 32'h500;
        wait_busy(n);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("arst_state", 32'(st), 32'(IDLE));
        chk("arst_done", 32'({bus.cpu_done, bus.ext_done, bus.cpu_err, bus.ext_err}), 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'd0);
        bus.ext_req = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_cpu_rd = '0;
        exp_ext_rd = '0;
        chk("arst_no_phantom", 32'(bus.cpu_done | bus.ext_done), 32'd0);
        run_txn(1'b0, 1'b0, 32'h600, 32'h0, 32'hCAFEF00D, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
